// File: rtl/program_sequencer_pkg.sv
// Shared types and defaults for the program sequencer: state encoding and the
// default program start-address table.
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD   = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

  localparam int DEFAULT_PC_WIDTH     = 10;
  localparam int DEFAULT_NUM_PROGRAMS = 3;

  // Program 0 occupies the least-significant PC_WIDTH bits.
  localparam logic [DEFAULT_NUM_PROGRAMS*DEFAULT_PC_WIDTH-1:0] DEFAULT_PROG_BASE =
    {10'd512, 10'd256, 10'd0};

endpackage

// File: rtl/program_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over enable
// and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;
  logic             w_at_max;

  assign w_at_max = &r_count;
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_en && !w_at_max) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Testbench-style program sequencer: waits for a start pulse, loads the PC with
// the selected program's base address, runs until halt or cycle limit.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int NUM_PROGRAMS = 3,
  parameter logic [NUM_PROGRAMS*PC_WIDTH-1:0] PROG_BASE = DEFAULT_PROG_BASE,
  parameter int CNT_WIDTH    = 16,
  parameter int MAX_CYCLES   = 0,
  localparam int SEL_W       = (NUM_PROGRAMS > 1) ? $clog2(NUM_PROGRAMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [SEL_W-1:0]     prog_sel,
  input  logic                 halt,
  output logic                 pc_load,
  output logic [PC_WIDTH-1:0]  pc_load_value,
  output logic                 run_en,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output seq_state_t           dbg_state
);

  localparam int TABLE_SIZE = 1 << SEL_W;
  localparam int LIMIT_INT  = (MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1;
  localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(LIMIT_INT);
  localparam logic [SEL_W:0] NUM_P = (SEL_W + 1)'(NUM_PROGRAMS);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [SEL_W-1:0]    r_idx;
  logic                r_timeout;
  logic                w_capture;
  logic                w_limit;
  logic                w_timeout_exit;
  logic [SEL_W-1:0]    w_idx_clamped;
  logic [PC_WIDTH-1:0] w_table [TABLE_SIZE];

  // Padded to a power of two so any captured index addresses a defined entry.
  for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_table
    if (g < NUM_PROGRAMS) begin : g_used
      assign w_table[g] = PROG_BASE[g*PC_WIDTH +: PC_WIDTH];
    end else begin : g_pad
      assign w_table[g] = '0;
    end
  end

  assign w_idx_clamped  = ({1'b0, prog_sel} < NUM_P) ? prog_sel : '0;
  assign w_capture      = (r_state == HOLD) && !start;
  assign w_limit        = (MAX_CYCLES != 0) && (cycle_count == LIMIT_M1);
  // Halt wins a same-cycle collision with the limit.
  assign w_timeout_exit = (r_state == RUN) && !halt && w_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = IDLE;
    pc_load       = 1'b0;
    pc_load_value = '0;
    run_en        = 1'b0;
    done          = 1'b0;
    case (r_state)
      IDLE:   w_next = start ? HOLD : IDLE;
      HOLD:   w_next = start ? HOLD : LOAD;
      LOAD: begin
        w_next        = RUN;
        pc_load       = 1'b1;
        pc_load_value = w_table[r_idx];
      end
      RUN: begin
        w_next = (halt || w_limit) ? FINISH : RUN;
        run_en = 1'b1;
      end
      FINISH: begin
        w_next = start ? HOLD : FINISH;
        done   = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
    end else if (w_capture) begin
      r_idx <= w_idx_clamped;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout <= 1'b0;
    end else if (r_state == LOAD) begin
      r_timeout <= 1'b0;
    end else if (w_timeout_exit) begin
      r_timeout <= 1'b1;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_cycle_counter (
    .clk     (clk),
    .rst     (reset),
    .i_clear (r_state == LOAD),
    .i_en    (r_state == RUN),
    .o_count (cycle_count)
  );

  assign timeout   = r_timeout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: a vector table for the basic run and
// restart, plus hand sequences for timeout, collision, saturation and reset.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] prog_sel;
  logic       halt;

  logic        a_pc_load, a_run_en, a_done, a_timeout;
  logic [9:0]  a_pcv;
  logic [15:0] a_cnt;
  seq_state_t  a_state;

  logic        b_pc_load, b_run_en, b_done, b_timeout;
  logic [9:0]  b_pcv;
  logic [15:0] b_cnt;
  seq_state_t  b_state;

  logic        c_pc_load, c_run_en, c_done, c_timeout;
  logic [9:0]  c_pcv;
  logic [3:0]  c_cnt;
  seq_state_t  c_state;

  int n_vec;
  int n_err;

  program_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .halt(halt),
    .pc_load(a_pc_load), .pc_load_value(a_pcv), .run_en(a_run_en), .done(a_done),
    .timeout(a_timeout), .cycle_count(a_cnt), .dbg_state(a_state)
  );

  program_sequencer #(.MAX_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .halt(halt),
    .pc_load(b_pc_load), .pc_load_value(b_pcv), .run_en(b_run_en), .done(b_done),
    .timeout(b_timeout), .cycle_count(b_cnt), .dbg_state(b_state)
  );

  program_sequencer #(.CNT_WIDTH(4)) dut_c (
    .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .halt(halt),
    .pc_load(c_pc_load), .pc_load_value(c_pcv), .run_en(c_run_en), .done(c_done),
    .timeout(c_timeout), .cycle_count(c_cnt), .dbg_state(c_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] sel;
    logic       halt;
    seq_state_t st;
    logic       pl;
    logic [9:0] pcv;
    logic       re;
    logic       dn;
    logic [15:0] cnt;
    logic       to;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; prog_sel = 2'd0; halt = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Leaves all DUTs sampled in LOAD.
  task automatic launch(input logic [1:0] sel);
    start = 1'b1; halt = 1'b0;
    tick();
    tick();
    start = 1'b0; prog_sel = sel;
    tick();
  endtask

  task automatic chk_a_all_zero(input string tag);
    chk({tag, "_state"}, 32'(a_state), 32'(IDLE));
    chk({tag, "_pl"},    32'(a_pc_load), 32'd0);
    chk({tag, "_pcv"},   32'(a_pcv), 32'd0);
    chk({tag, "_re"},    32'(a_run_en), 32'd0);
    chk({tag, "_done"},  32'(a_done), 32'd0);
    chk({tag, "_to"},    32'(a_timeout), 32'd0);
    chk({tag, "_cnt"},   32'(a_cnt), 32'd0);
  endtask

  initial begin
    int b_runs;
    n_vec = 0;
    n_err = 0;

    //            start sel halt  state   pl pcv  re dn cnt to
    tbl[0]  = '{1'b1, 2'd0, 1'b0, HOLD,   1'b0, 10'd0,   1'b0, 1'b0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, HOLD,   1'b0, 10'd0,   1'b0, 1'b0, 16'd0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, HOLD,   1'b0, 10'd0,   1'b0, 1'b0, 16'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd1, 1'b0, LOAD,   1'b1, 10'd256, 1'b0, 1'b0, 16'd0, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd0, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd2, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd3, 1'b0};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd4, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b1, FINISH, 1'b0, 10'd0,   1'b0, 1'b1, 16'd5, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b1, FINISH, 1'b0, 10'd0,   1'b0, 1'b1, 16'd5, 1'b0};
    tbl[11] = '{1'b1, 2'd0, 1'b0, HOLD,   1'b0, 10'd0,   1'b0, 1'b0, 16'd5, 1'b0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, LOAD,   1'b1, 10'd0,   1'b0, 1'b0, 16'd5, 1'b0};
    tbl[13] = '{1'b1, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd1, 1'b0};
    tbl[15] = '{1'b1, 2'd0, 1'b0, RUN,    1'b0, 10'd0,   1'b1, 1'b0, 16'd2, 1'b0};
    tbl[16] = '{1'b0, 2'd0, 1'b1, FINISH, 1'b0, 10'd0,   1'b0, 1'b1, 16'd3, 1'b0};

    do_reset();
    chk_a_all_zero("reset");

    // Basic run, restart, out-of-range select, start ignored in RUN.
    for (int i = 0; i < 17; i++) begin
      start = tbl[i].start; prog_sel = tbl[i].sel; halt = tbl[i].halt;
      tick();
      chk($sformatf("v%0d_state", i), 32'(a_state),   32'(tbl[i].st));
      chk($sformatf("v%0d_pl", i),    32'(a_pc_load), 32'(tbl[i].pl));
      chk($sformatf("v%0d_pcv", i),   32'(a_pcv),     32'(tbl[i].pcv));
      chk($sformatf("v%0d_re", i),    32'(a_run_en),  32'(tbl[i].re));
      chk($sformatf("v%0d_done", i),  32'(a_done),    32'(tbl[i].dn));
      chk($sformatf("v%0d_cnt", i),   32'(a_cnt),     32'(tbl[i].cnt));
      chk($sformatf("v%0d_to", i),    32'(a_timeout), 32'(tbl[i].to));
    end

    // Timeout on dut_b, saturation on dut_c, 20-cycle run on dut_a.
    do_reset();
    launch(2'd2);
    chk("long_pcv", 32'(a_pcv), 32'd512);
    b_runs = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b_run_en) b_runs++;
    end
    chk("to_b_runs", 32'(b_runs), 32'd8);
    chk("to_b_done", 32'(b_done), 32'd1);
    chk("to_b_flag", 32'(b_timeout), 32'd1);
    chk("to_b_cnt",  32'(b_cnt), 32'd8);
    chk("sat_c_run", 32'(c_run_en), 32'd1);
    chk("sat_c_cnt", 32'(c_cnt), 32'd15);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("long_a_cnt",  32'(a_cnt), 32'd20);
    chk("long_a_done", 32'(a_done), 32'd1);
    chk("sat_c_final", 32'(c_cnt), 32'd15);
    chk("to_b_held",   32'(b_timeout), 32'd1);
    // A fresh LOAD on dut_b clears the sticky timeout.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("to_b_clr", 32'(b_timeout), 32'd0);

    // Halt and limit collide on the 8th RUN cycle: halt wins.
    do_reset();
    launch(2'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("col_b_cnt_pre", 32'(b_cnt), 32'd7);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("col_b_state", 32'(b_state), 32'(FINISH));
    chk("col_b_to",    32'(b_timeout), 32'd0);
    chk("col_b_cnt",   32'(b_cnt), 32'd8);

    // Asynchronous reset in RUN cycle 3, then a normal run.
    do_reset();
    launch(2'd1);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_pre_cnt", 32'(a_cnt), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk_a_all_zero("mid_rst");
    tick();
    reset = 1'b0;
    tick();
    chk("mid_idle", 32'(a_state), 32'(IDLE));
    launch(2'd2);
    chk("mid_pl",  32'(a_pc_load), 32'd1);
    chk("mid_pcv", 32'(a_pcv), 32'd512);
    tick();
    tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("mid_done", 32'(a_done), 32'd1);
    chk("mid_cnt",  32'(a_cnt), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
